// File: rtl/keccak_pkg.sv
// Shared definitions for the SHAKE core pipeline: lane geometry, rate sizes
// and the output buffer stage state encoding.
package keccak_pkg;

    localparam int LANE_W        = 64;
    localparam int RATE128_WORDS = 21;
    localparam int RATE256_WORDS = 17;
    localparam int MAX_RATE_BITS = 1344;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ob_state_e;

endpackage

// File: rtl/output_buffer_stage_if.sv
// Valid/ready word stream leaving the output buffer stage, one Keccak lane
// per transfer with a marker on the final word of the digest.
interface output_buffer_stage_if;
    import keccak_pkg::*;

    logic [LANE_W-1:0] dout;
    logic              dout_valid;
    logic              dout_last;
    logic              dout_ready;

    modport master (
        output dout,
        output dout_valid,
        output dout_last,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  dout_last,
        output dout_ready
    );

endinterface

// File: rtl/output_buffer_stage.sv
// Third SHAKE pipeline stage: captures one squeezed rate block and streams it
// out lane by lane, truncating the final block to the requested digest length.
module output_buffer_stage
    import keccak_pkg::*;
#(
    parameter int MAX_RATE_WORDS = RATE128_WORDS,
    parameter int IDX_W          = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [LANE_W*MAX_RATE_WORDS-1:0] block_in,
    input  logic                             output_buffer_we,
    input  logic                             last_output_block_wr,
    input  logic [IDX_W-1:0]                 rate_words,
    input  logic [IDX_W-1:0]                 last_block_words,
    input  logic                             output_buffer_available_clr,
    output logic                             output_buffer_available,
    output_buffer_stage_if.master            out_if
);

    localparam int              BUF_W     = LANE_W * MAX_RATE_WORDS;
    localparam logic [IDX_W-1:0] MAX_WORDS = IDX_W'(MAX_RATE_WORDS);
    localparam logic [IDX_W-1:0] R128      = IDX_W'(RATE128_WORDS);
    localparam logic [IDX_W-1:0] R256      = IDX_W'(RATE256_WORDS);
    localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);

    ob_state_e         state_q, state_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [IDX_W-1:0]  count_q, count_new;
    logic [IDX_W-1:0]  rate_eff;
    logic              rate_ok;
    logic              last_q;
    logic              load;
    logic              finish;
    logic              is_final;
    logic              valid;
    logic [BUF_W-1:0]  buffer_q;

    // Illegal rate or tail lengths are clamped so the counter can never walk
    // past the captured lanes.
    always_comb begin
        rate_ok  = ((rate_words == R128) || (rate_words == R256)) && (rate_words <= MAX_WORDS);
        rate_eff = rate_ok ? rate_words : MAX_WORDS;
        if (!last_output_block_wr || (last_block_words == '0)) begin
            count_new = rate_eff;
        end else if (last_block_words > rate_eff) begin
            count_new = rate_eff;
        end else begin
            count_new = last_block_words;
        end
    end

    assign is_final = (index_q == (count_q - ONE));
    assign valid    = (state_q == STREAM);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        load    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (output_buffer_we && output_buffer_available) begin
                    load    = 1'b1;
                    index_d = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_if.dout_ready) begin
                    if (is_final) begin
                        finish  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        index_d = index_q + ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            index_q <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            if (load) begin
                count_q <= count_new;
                last_q  <= last_output_block_wr;
            end
        end
    end

    // NOTE: the wide data buffer is deliberately not reset; dout is masked while invalid.
    always_ff @(posedge clk) begin
        if (load && !rst) begin
            buffer_q <= block_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            output_buffer_available <= 1'b1;
        end else if (output_buffer_available_clr) begin
            output_buffer_available <= 1'b0;
        end else if (finish) begin
            output_buffer_available <= 1'b1;
        end
    end

    assign out_if.dout_valid = valid;
    assign out_if.dout_last  = valid && last_q && is_final;
    assign out_if.dout       = valid ? buffer_q[LANE_W*int'(index_q) +: LANE_W] : '0;

    a_write_only_when_free: assert property (@(posedge clk) disable iff (rst)
        output_buffer_we |-> ((state_q == IDLE) && output_buffer_available));

    a_rate_words_legal: assert property (@(posedge clk) disable iff (rst)
        load |-> rate_ok);

    a_last_words_legal: assert property (@(posedge clk) disable iff (rst)
        (load && last_output_block_wr) |-> (last_block_words <= rate_words));

endmodule
